// File: rtl/eth_rmii_txrx.sv
// eth_rmii_txrx
// RMII (100 Mb/s, 50 MHz reference clock) byte-stream transmitter and receiver.
//
// Transmit path: on request, emits 7 x 0x55 preamble and the 0xD5 SFD, then
// client bytes LSB-first as dibits.
// Receive path: strips the preamble and SFD, then delivers bytes with a
// valid strobe and an end-of-packet strobe.
//
// Ports
//   clk50       in   50 MHz RMII reference clock (single clock domain)
//   reset       in   asynchronous, active-high reset
//   tx0, tx1    out  RMII TXD[0], TXD[1]; forced to 0 while txen is low
//   txen        out  RMII TX_EN
//   tx_data     in   byte to send, captured in the cycle tx_advance is high
//   tx_packet   in   client has bytes to send; sampled in IDLE and at capture points
//   tx_busy     out  high from frame start through the inter-packet gap
//   tx_advance  out  1-cycle pulse: tx_data is captured at the end of this cycle
//   rx0, rx1    in   RMII RXD[0], RXD[1]
//   crs_dv      in   RMII CRS_DV
//   rx_data     out  received byte, valid while rx_valid is high
//   rx_valid    out  1-cycle strobe per received byte
//   rx_eop      out  1-cycle strobe at end of a received frame
module eth_rmii_txrx (
    input  logic       clk50,
    input  logic       reset,
    output logic       tx0,
    output logic       tx1,
    output logic       txen,
    input  logic [7:0] tx_data,
    input  logic       tx_packet,
    output logic       tx_busy,
    output logic       tx_advance,
    input  logic       rx0,
    input  logic       rx1,
    input  logic       crs_dv,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_eop
);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_PREAMBLE, TX_DATA, TX_IPG} tx_state_t;

    tx_state_t  tx_state;
    logic [5:0] tx_cnt;    // preamble dibit 0..31, data dibit 0..3, IPG clock 0..47
    logic [5:0] tx_shift;  // remaining dibits of the byte on the wire
    logic       tx_boundary;

    // Last dibit of the SFD or of a data byte: the next byte starts here or the
    // frame ends. tx_advance was already decided when this cycle was entered.
    assign tx_boundary = ((tx_state == TX_PREAMBLE) && (tx_cnt == 6'd31)) ||
                         ((tx_state == TX_DATA) && (tx_cnt[1:0] == 2'd3));

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= 6'd0;
            // NOTE: the datapath shift register is reset along with the control
            // state so no X can ever reach the pins after reset.
            tx_shift   <= 6'd0;
            txen       <= 1'b0;
            tx0        <= 1'b0;
            tx1        <= 1'b0;
            tx_busy    <= 1'b0;
            tx_advance <= 1'b0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignments so every
            // register in this block sees the values from before the edge.
            tx_advance <= 1'b0;
            if (tx_boundary) begin
                if (tx_advance) begin
                    tx_state       <= TX_DATA;
                    tx_cnt         <= 6'd0;
                    {tx1, tx0}     <= tx_data[1:0];
                    tx_shift       <= tx_data[7:2];
                end else begin
                    tx_state       <= TX_IPG;
                    tx_cnt         <= 6'd0;
                    txen           <= 1'b0;
                    {tx1, tx0}     <= 2'b00;
                end
            end else begin
                case (tx_state)
                    TX_IDLE: begin
                        if (tx_packet) begin
                            tx_state   <= TX_PREAMBLE;
                            tx_cnt     <= 6'd0;
                            txen       <= 1'b1;
                            {tx1, tx0} <= 2'b01;
                            tx_busy    <= 1'b1;
                        end
                    end
                    TX_PREAMBLE: begin
                        tx_cnt     <= tx_cnt + 6'd1;
                        // Entering dibit 31: the SFD tail and the first capture point.
                        {tx1, tx0} <= (tx_cnt == 6'd30) ? 2'b11 : 2'b01;
                        tx_advance <= (tx_cnt == 6'd30) && tx_packet;
                    end
                    TX_DATA: begin
                        tx_cnt     <= tx_cnt + 6'd1;
                        {tx1, tx0} <= tx_shift[1:0];
                        tx_shift   <= {2'b00, tx_shift[5:2]};
                        tx_advance <= (tx_cnt[1:0] == 2'd2) && tx_packet;
                    end
                    TX_IPG: begin
                        if (tx_cnt == 6'd47) begin
                            tx_state <= TX_IDLE;
                            tx_busy  <= 1'b0;
                        end else begin
                            tx_cnt   <= tx_cnt + 6'd1;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_HUNT, RX_DATA} rx_state_t;

    rx_state_t  rx_state;
    logic       rx0_q, rx1_q, crs_q;   // pins registered once
    logic [1:0] rx_cnt;                // dibit index within the current byte
    logic [5:0] rx_shift;              // first three dibits, LSB dibit lowest
    logic [7:0] rx_byte;
    logic       rx_byte_done;
    logic       rx_end;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            rx_state     <= RX_IDLE;
            rx0_q        <= 1'b0;
            rx1_q        <= 1'b0;
            crs_q        <= 1'b0;
            rx_cnt       <= 2'd0;
            rx_shift     <= 6'd0;
            rx_byte      <= 8'h00;
            rx_byte_done <= 1'b0;
            rx_end       <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_eop       <= 1'b0;
        end else begin
            rx0_q        <= rx0;
            rx1_q        <= rx1;
            crs_q        <= crs_dv;
            rx_byte_done <= 1'b0;
            rx_end       <= 1'b0;

            // Output stage: one more register after the FSM decision.
            rx_valid     <= rx_byte_done;
            rx_eop       <= rx_end;
            if (rx_byte_done) begin
                rx_data  <= rx_byte;
            end

            case (rx_state)
                RX_IDLE: begin
                    if (crs_q) begin
                        rx_state <= RX_HUNT;
                    end
                end
                RX_HUNT: begin
                    if (!crs_q) begin
                        rx_state <= RX_IDLE;
                    end else if ({rx1_q, rx0_q} == 2'b11) begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= 2'd0;
                    end else if ({rx1_q, rx0_q} != 2'b01) begin
                        rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (!crs_q) begin
                        // Any partial byte in rx_shift is simply dropped.
                        rx_state <= RX_IDLE;
                        rx_end   <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 2'd1;
                        if (rx_cnt == 2'd3) begin
                            rx_byte      <= {rx1_q, rx0_q, rx_shift};
                            rx_byte_done <= 1'b1;
                        end else begin
                            rx_shift     <= {rx1_q, rx0_q, rx_shift[5:2]};
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rmii_txrx.sv
// tb_eth_rmii_txrx
// Directed bench for eth_rmii_txrx: loopback frame, preamble layout, RX glitch,
// RX partial byte, back-to-back request and reset during transmission.
// Outputs are sampled on the falling edge; cycle numbers count falling edges.
module tb_eth_rmii_txrx;

    logic       clk50 = 1'b0;
    logic       reset;
    logic       tx0, tx1, txen;
    logic [7:0] tx_data;
    logic       tx_packet;
    logic       tx_busy, tx_advance;
    logic       rx0, rx1, crs_dv;
    logic [7:0] rx_data;
    logic       rx_valid, rx_eop;

    logic       loop_en;
    logic       drv_rx0, drv_rx1, drv_crs;

    assign rx0    = loop_en ? tx0  : drv_rx0;
    assign rx1    = loop_en ? tx1  : drv_rx1;
    assign crs_dv = loop_en ? txen : drv_crs;

    always #10 clk50 = ~clk50;

    eth_rmii_txrx dut (
        .clk50      (clk50),
        .reset      (reset),
        .tx0        (tx0),
        .tx1        (tx1),
        .txen       (txen),
        .tx_data    (tx_data),
        .tx_packet  (tx_packet),
        .tx_busy    (tx_busy),
        .tx_advance (tx_advance),
        .rx0        (rx0),
        .rx1        (rx1),
        .crs_dv     (crs_dv),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_eop     (rx_eop)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Recorders, all written by the single stimulus process via tick().
    int         cyc = 0;
    int         adv_q[$];
    logic [7:0] rxb_q[$];
    int         rxv_q[$];
    logic [1:0] txd_q[$];
    int         eop_cnt = 0, eop_cyc = 0, both_cnt = 0, idle_bad = 0;
    int         txen_rise = -1, txen_fall = -1, busy_fall = -1;
    logic       txen_prev = 1'b0, busy_prev = 1'b0;
    logic       busy_fell = 1'b0;

    // Byte feeder: after each tx_advance, present the next byte or drop tx_packet.
    logic [7:0] bytes [16];
    int         feed_idx = 0, feed_n = 0;
    logic       pend_adv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50);
        #1;
        if (pend_adv) begin
            pend_adv = 1'b0;
            feed_idx++;
            if (feed_idx < feed_n) tx_data = bytes[feed_idx];
            else                   tx_packet = 1'b0;
        end
        @(negedge clk50);
        cyc++;
        if (tx_advance) begin
            adv_q.push_back(cyc);
            pend_adv = 1'b1;
        end
        if (rx_valid) begin
            rxb_q.push_back(rx_data);
            rxv_q.push_back(cyc);
        end
        if (rx_eop) begin
            eop_cnt++;
            eop_cyc = cyc;
        end
        if (rx_valid && rx_eop) both_cnt++;
        if (!txen && (tx0 || tx1)) idle_bad++;
        if (txen && !txen_prev) begin
            txen_rise = cyc;
            txd_q.delete();
        end
        if (!txen && txen_prev) txen_fall = cyc;
        if (txen) txd_q.push_back({tx1, tx0});
        if (!tx_busy && busy_prev) begin
            busy_fall = cyc;
            busy_fell = 1'b1;
        end
        txen_prev = txen;
        busy_prev = tx_busy;
    endtask

    task automatic wait_busy_fall(input int budget, input string tag);
        for (int i = 0; i < budget && !busy_fell; i++) tick();
        check(tag, {31'd0, busy_fell}, 32'd1);
    endtask

    task automatic rx_dibit(input logic c, input logic [1:0] d);
        drv_crs = c;
        {drv_rx1, drv_rx0} = d;
        tick();
    endtask

    initial begin
        int r, n_adv0, n_rx0, eop0, bad, old_rise, old_fall;
        logic [7:0] b;
        logic [1:0] part_seq [13];

        bytes = '{8'hFF, 8'h01, 8'h77, 8'hAA, 8'h00, 8'h10, 8'h20, 8'h30,
                  8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hAA, 8'h55};
        part_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11,
                     2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};

        reset = 1'b1;
        tx_packet = 1'b0;
        tx_data = 8'h00;
        loop_en = 1'b1;
        drv_rx0 = 1'b0;
        drv_rx1 = 1'b0;
        drv_crs = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_txen",    {31'd0, txen}, 32'd0);
        check("rst_txd",     {30'd0, tx1, tx0}, 32'd0);
        check("rst_busy",    {31'd0, tx_busy}, 32'd0);
        check("rst_adv",     {31'd0, tx_advance}, 32'd0);
        check("rst_rxstrb",  {30'd0, rx_valid, rx_eop}, 32'd0);
        check("rst_rxdata",  {24'd0, rx_data}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", {28'd0, txen, tx_busy, rx_valid, rx_eop}, 32'd0);

        // ---------------- loopback, 16 bytes ----------------
        n_adv0 = adv_q.size();
        n_rx0 = rxb_q.size();
        eop0 = eop_cnt;
        busy_fell = 1'b0;
        feed_idx = 0;
        feed_n = 16;
        tx_data = bytes[0];
        tx_packet = 1'b1;
        wait_busy_fall(400, "lb_done");
        r = txen_rise;

        check("lb_adv_count", adv_q.size() - n_adv0, 32'd16);
        check("lb_first_adv", adv_q[n_adv0] - r, 32'd31);
        bad = 0;
        for (int i = 1; i < 16; i++)
            if (adv_q[n_adv0 + i] - adv_q[n_adv0 + i - 1] != 4) bad++;
        check("lb_adv_spacing", bad, 32'd0);
        check("lb_txen_len", txen_fall - r, 32'd96);
        check("lb_dibit_count", txd_q.size(), 32'd96);
        bad = 0;
        for (int i = 0; i < 31; i++) if (txd_q[i] != 2'b01) bad++;
        if (txd_q[31] != 2'b11) bad++;
        check("lb_preamble", bad, 32'd0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            b = bytes[i];
            for (int j = 0; j < 4; j++)
                if (txd_q[32 + 4 * i + j] != b[2 * j +: 2]) bad++;
        end
        check("lb_data_dibits", bad, 32'd0);
        check("lb_ipg", busy_fall - txen_fall, 32'd48);
        check("lb_rx_count", rxb_q.size() - n_rx0, 32'd16);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rxb_q[n_rx0 + i] != bytes[i]) bad++;
        check("lb_rx_bytes", bad, 32'd0);
        check("lb_rx_latency", rxv_q[n_rx0] - r, 32'd38);
        check("lb_eop_count", eop_cnt - eop0, 32'd1);
        check("lb_eop_latency", eop_cyc - r, 32'd99);

        // ---------------- RX glitch: 3 cycles of 01, no SFD ----------------
        loop_en = 1'b0;
        n_rx0 = rxb_q.size();
        eop0 = eop_cnt;
        repeat (3) rx_dibit(1'b1, 2'b01);
        repeat (6) rx_dibit(1'b0, 2'b00);
        check("glitch_no_valid", rxb_q.size() - n_rx0, 32'd0);
        check("glitch_no_eop", eop_cnt - eop0, 32'd0);

        // ---------------- RX partial byte after 0xA5 ----------------
        n_rx0 = rxb_q.size();
        eop0 = eop_cnt;
        for (int i = 0; i < 11; i++) rx_dibit(1'b1, part_seq[i]);
        repeat (6) rx_dibit(1'b0, 2'b00);
        check("part_rx_count", rxb_q.size() - n_rx0, 32'd1);
        check("part_rx_byte", {24'd0, rxb_q[rxb_q.size() - 1]}, 32'hA5);
        check("part_eop_count", eop_cnt - eop0, 32'd1);
        check("part_eop_after", {31'd0, eop_cyc > rxv_q[rxv_q.size() - 1]}, 32'd1);

        // ---------------- back-to-back request ----------------
        loop_en = 1'b1;
        busy_fell = 1'b0;
        feed_idx = 0;
        feed_n = 1;
        tx_data = 8'h3C;
        tx_packet = 1'b1;
        repeat (45) tick();
        check("b2b_in_ipg", {30'd0, txen, tx_busy}, 32'd1);
        tx_packet = 1'b1;
        wait_busy_fall(100, "b2b_first_done");
        old_rise = txen_rise;
        feed_idx = 0;
        feed_n = 1;
        for (int i = 0; i < 10 && txen_rise == old_rise; i++) tick();
        check("b2b_restart", txen_rise - busy_fall, 32'd1);
        busy_fell = 1'b0;
        wait_busy_fall(200, "b2b_second_done");
        check("b2b_second_len", txd_q.size(), 32'd36);

        // ---------------- reset during byte 3 ----------------
        busy_fell = 1'b0;
        n_adv0 = adv_q.size();
        feed_idx = 0;
        feed_n = 16;
        tx_data = bytes[0];
        tx_packet = 1'b1;
        for (int i = 0; i < 200 && adv_q.size() - n_adv0 < 3; i++) tick();
        check("rst_reach_b3", adv_q.size() - n_adv0, 32'd3);
        tick();
        tick();
        check("rst_pre_txen", {31'd0, txen}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_txen", {31'd0, txen}, 32'd0);
        check("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_mid_adv", {31'd0, tx_advance}, 32'd0);
        pend_adv = 1'b0;
        tx_packet = 1'b0;
        eop0 = eop_cnt;
        n_rx0 = rxb_q.size();
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("rst_no_eop", eop_cnt - eop0, 32'd0);

        old_fall = txen_fall;
        busy_fell = 1'b0;
        feed_idx = 0;
        feed_n = 1;
        tx_data = bytes[0];
        tx_packet = 1'b1;
        wait_busy_fall(200, "fresh_done");
        bad = 0;
        for (int i = 0; i < 31; i++) if (txd_q[i] != 2'b01) bad++;
        if (txd_q[31] != 2'b11) bad++;
        check("fresh_preamble", bad, 32'd0);
        check("fresh_len", txen_fall - txen_rise, 32'd36);
        check("fresh_rx_byte", {24'd0, rxb_q[rxb_q.size() - 1]}, 32'hFF);
        check("fresh_rx_count", rxb_q.size() - n_rx0, 32'd1);

        // ---------------- whole-run invariants ----------------
        check("never_valid_and_eop", both_cnt, 32'd0);
        check("txd_zero_when_idle", idle_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_rmii_txrx.md
# eth_rmii_txrx

RMII (100 Mb/s, 50 MHz reference clock) byte-stream transmitter and receiver. The transmit path turns a byte stream from a client into an RMII frame with preamble and SFD. The receive path strips the preamble and SFD from an incoming RMII frame and delivers bytes plus an end-of-packet strobe. It sits between the MAC/packet logic and the external RMII PHY pins. The TX pins may be looped directly to the RX pins for self-test.

## Interface
- No parameters.
- `clk50` in 1: 50 MHz RMII reference clock. One clock for the whole block.
- `reset` in 1: asynchronous, active-high reset.
- `tx0`, `tx1` out 1: RMII TXD[0], TXD[1].
- `txen` out 1: RMII TX_EN.
- `tx_data` in 8: byte to transmit; sampled only in the cycle `tx_advance` is high.
- `tx_packet` in 1: client has a frame or more bytes to send; hold high until the last byte is consumed.
- `tx_busy` out 1: transmitter active, from frame start through the inter-packet gap.
- `tx_advance` out 1: 1-cycle pulse meaning `tx_data` was captured this cycle; present the next byte by the next capture point.
- `rx0`, `rx1` in 1: RMII RXD[0], RXD[1].
- `crs_dv` in 1: RMII CRS_DV.
- `rx_data` out 8: received byte, valid while `rx_valid` is high.
- `rx_valid` out 1: 1-cycle strobe, one per received byte.
- `rx_eop` out 1: 1-cycle strobe at end of a received frame.

## Operation
- Dibit order is LSB first: byte b goes out as {b1,b0}, {b3,b2}, {b5,b4}, {b7,b6}, with TXD0 carrying the even bit. This is 4 clocks per byte.
- **TX states:** IDLE → PREAMBLE → DATA → IPG → IDLE.
  - **IDLE:** `tx_busy`=0. Sampling `tx_packet`=1 enters PREAMBLE.
  - **PREAMBLE:** sends 7×0x55 then 0xD5 (SFD), 32 clocks. SFD dibits are 01,01,01,11 as {tx1,tx0}.
  - **Capture points:** the final dibit cycle of SFD and of every data byte.
    - If `tx_packet`=1 there: latch `tx_data` into the shift register, pulse `tx_advance`, and continue in DATA.
    - If `tx_packet`=0 there: the frame ends after the current dibit.
    - A frame whose `tx_packet` is low at the first capture point sends preamble+SFD only.
  - **No FCS:** the transmitter does not append an FCS. The frame is exactly the supplied bytes.
  - **IPG:** `txen`=0 and `tx_busy`=1 for 48 clocks (96 bit times), then IDLE.
  - `tx_packet` is ignored outside IDLE and outside capture points.
- When `txen`=0, `tx0`=`tx1`=0.
- **RX states:** IDLE → HUNT → DATA.
  - Inputs are registered once before use.
  - **IDLE:** `crs_dv`=1 enters HUNT.
  - **HUNT:** skips dibits 01 (preamble). Dibit 11 (SFD tail) enters DATA with the byte-dibit counter at 0. Any other dibit, or `crs_dv`=0, returns to IDLE with no `rx_eop`.
  - **DATA:** shifts dibits into a byte LSB first. After the 4th dibit, outputs the byte on `rx_data` and pulses `rx_valid`.
  - **End of frame:** the first registered `crs_dv`=0 in DATA ends the frame. Pulse `rx_eop` once, discard any partial byte, return to IDLE.
  - The receiver performs no FCS check and no address filtering.

## Timing
- **Reset values:** `txen`, `tx0`, `tx1`, `tx_busy`, `tx_advance`, `rx_valid`, `rx_eop` = 0; `rx_data` = 0x00. Both FSMs are in IDLE.
- **Reset mid-frame:** `txen` drops immediately (async), and no `rx_eop` is generated for the aborted frame.
- **TX start:** `tx_packet` sampled high at edge E. Then `txen`=1 with first preamble dibit (`tx0`=1, `tx1`=0) and `tx_busy`=1 from E onward.
- **First `tx_advance`:** the cycle starting at E+31 (last SFD dibit). The first data dibit appears at E+32.
- **Later `tx_advance`:** every 4 cycles while `tx_packet` stays high.
- **Client response:** it may drop `tx_packet` registered on the last `tx_advance`; the frame then ends after that byte's 4 dibits.
- **TX end:** `txen` falls on the edge after the last dibit cycle. `tx_busy` falls 48 clocks later.
- **RX byte latency:** `rx_valid` is high in the cycle starting 2 edges after the edge that samples the byte's 4th dibit at the pins.
- **RX end latency:** `rx_eop` follows the same 2-edge latency after the first sampled `crs_dv`=0.
- **RX strobe spacing:** `rx_valid` and `rx_eop` are never high together. The `rx_eop` for a whole-byte frame comes at least 1 cycle after the last `rx_valid`.

## Test plan
- **Loopback:** tx pins wired to rx pins. Send 16 bytes FF 01 77 AA 00 10 20 30 40 50 60 70 80 90 AA 55, dropping `tx_packet` on the 16th `tx_advance`.
  - Required: exactly 16 `tx_advance` pulses, 4 cycles apart.
  - Required: 16 `rx_valid` strobes with those bytes in order, then one `rx_eop`.
  - Required: `tx_busy` falls 48 clocks after `txen`.
- **Preamble check:** `txen` is high for 32+4N cycles. The first 28 cycles show {tx1,tx0}=01, cycles 29–31 show 01, and cycle 32 shows 11.
- **Back-to-back request:** `tx_packet` held high through the IPG. The second frame's `txen` does not rise until `tx_busy` has returned to 0 for the cycle IDLE samples.
- **RX glitch:** `crs_dv` pulsed high for 3 cycles with dibits 01 and no SFD. Required: no `rx_valid` and no `rx_eop`.
- **RX partial byte:** SFD, one byte 0xA5, then 2 extra dibits, then `crs_dv`=0. Required: one `rx_valid` with 0xA5, then one `rx_eop`, and no second byte.
- **Reset mid-TX:** assert `reset` during byte 3. Required: `txen`=0, `tx_busy`=0, `tx_advance`=0 immediately. The next `tx_packet` starts a fresh preamble.
